// File: rtl/mux_scan.sv
// mux_scan: N-channel, W-bit registered multiplexer with two modes.
//   mode = 0 : manual select, f follows the channel chosen by sel.
//   mode = 1 : scan, round-robin over all channels, DWELL enabled cycles each.
// All outputs are registered; there is no combinational input-to-output path.
module mux_scan #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 4,
    localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          f,
    output logic [SEL_W-1:0]          f_ch,
    output logic                      f_valid,
    output logic                      wrap
);

    // Dwell counter width; a DWELL of 1 still keeps a 1-bit counter that stays at 0.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);
    // Channel count one bit wider than sel so the range test never overflows.
    localparam logic [SEL_W:0]   CH_NUM   = (SEL_W + 1)'(CHANNELS);

    // Returns the slice for channel idx; an illegal idx yields zero (never used).
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [CHANNELS*WIDTH-1:0] d,
        input logic [SEL_W-1:0]          idx
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                res = d[k*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    logic [SEL_W-1:0] ptr_r;
    logic [CNT_W-1:0] cnt_r;

    logic [SEL_W-1:0] ptr_s;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] f_s;
    logic [SEL_W-1:0] f_ch_s;
    logic             f_valid_s;
    logic             wrap_s;
    logic             sel_ok_s;

    // Manual select is legal only when it names an existing channel.
    always_comb begin
        sel_ok_s = ({1'b0, sel} < CH_NUM);
    end

    // Next-state and next-output selection for manual, scan and stalled cycles.
    always_comb begin
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        f_s       = f;
        f_ch_s    = f_ch;
        f_valid_s = 1'b0;
        wrap_s    = 1'b0;
        if (!en) begin
            // Stall: position and sample hold, the stream is marked not fresh.
            ptr_s = ptr_r;
        end else if (!mode) begin
            // Manual: cnt is cleared so a later switch to scan gets a full dwell.
            cnt_s = '0;
            if (sel_ok_s) begin
                f_s       = pick_channel(data_in, sel);
                f_ch_s    = sel;
                ptr_s     = sel;
                f_valid_s = 1'b1;
            end else begin
                ptr_s = ptr_r;
            end
        end else begin
            f_s       = pick_channel(data_in, ptr_r);
            f_ch_s    = ptr_r;
            f_valid_s = 1'b1;
            if (cnt_r == CNT_LAST) begin
                cnt_s = '0;
                if (ptr_r == CH_LAST) begin
                    ptr_s  = '0;
                    wrap_s = 1'b1;
                end else begin
                    ptr_s  = ptr_r + SEL_W'(1);
                    wrap_s = 1'b0;
                end
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r   <= '0;
            cnt_r   <= '0;
            f       <= '0;
            f_ch    <= '0;
            f_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            f       <= f_s;
            f_ch    <= f_ch_s;
            f_valid <= f_valid_s;
            wrap    <= wrap_s;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan using three configurations:
//   u0: WIDTH=8, CHANNELS=4, DWELL=2
//   u1: WIDTH=8, CHANNELS=5, DWELL=1
//   u2: WIDTH=8, CHANNELS=4, DWELL=4
module tb_mux_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // u0 signals
    logic        rst0 = 1'b0, en0 = 1'b0, mode0 = 1'b0;
    logic [1:0]  sel0 = 2'd0;
    logic [31:0] data0 = 32'd0;
    logic [7:0]  f0;
    logic [1:0]  ch0;
    logic        v0, w0;

    // u1 signals
    logic        rst1 = 1'b0, en1 = 1'b0, mode1 = 1'b0;
    logic [2:0]  sel1 = 3'd0;
    logic [39:0] data1 = 40'd0;
    logic [7:0]  f1;
    logic [2:0]  ch1;
    logic        v1, w1;

    // u2 signals
    logic        rst2 = 1'b0, en2 = 1'b0, mode2 = 1'b0;
    logic [1:0]  sel2 = 2'd0;
    logic [31:0] data2 = 32'd0;
    logic [7:0]  f2;
    logic [1:0]  ch2;
    logic        v2, w2;

    int seq3[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int seq5[11] = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    int seq1[6]  = '{4, 0, 1, 2, 3, 4};

    mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) u0 (
        .clk(clk), .rst_n(rst0), .data_in(data0), .en(en0), .mode(mode0),
        .sel(sel0), .f(f0), .f_ch(ch0), .f_valid(v0), .wrap(w0));

    mux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) u1 (
        .clk(clk), .rst_n(rst1), .data_in(data1), .en(en1), .mode(mode1),
        .sel(sel1), .f(f1), .f_ch(ch1), .f_valid(v1), .wrap(w1));

    mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u2 (
        .clk(clk), .rst_n(rst2), .data_in(data2), .en(en2), .mode(mode2),
        .sel(sel2), .f(f2), .f_ch(ch2), .f_valid(v2), .wrap(w2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp0(input string tag, input int f, input int ch, input int v, input int w);
        check({tag, ".f"},     32'(f0), 32'(f));
        check({tag, ".f_ch"},  32'(ch0), 32'(ch));
        check({tag, ".valid"}, 32'(v0), 32'(v));
        check({tag, ".wrap"},  32'(w0), 32'(w));
    endtask

    task automatic exp1(input string tag, input int f, input int ch, input int v, input int w);
        check({tag, ".f"},     32'(f1), 32'(f));
        check({tag, ".f_ch"},  32'(ch1), 32'(ch));
        check({tag, ".valid"}, 32'(v1), 32'(v));
        check({tag, ".wrap"},  32'(w1), 32'(w));
    endtask

    task automatic exp2(input string tag, input int f, input int ch, input int v, input int w);
        check({tag, ".f"},     32'(f2), 32'(f));
        check({tag, ".f_ch"},  32'(ch2), 32'(ch));
        check({tag, ".valid"}, 32'(v2), 32'(v));
        check({tag, ".wrap"},  32'(w2), 32'(w));
    endtask

    initial begin
        #1;
        // ---- 1. reset held over two edges with scan requested and data toggling
        rst0 = 1'b0; mode0 = 1'b1; en0 = 1'b1; data0 = 32'hDEADBEEF;
        step();
        exp0("rst_edge1", 8'h00, 0, 0, 0);
        data0 = 32'h12345678;
        step();
        exp0("rst_edge2", 8'h00, 0, 0, 0);

        // ---- 2. manual select
        rst0 = 1'b1; mode0 = 1'b0; data0 = {8'h44, 8'h33, 8'h22, 8'h11}; sel0 = 2'd2;
        step();
        exp0("man_sel2", 8'h33, 2, 1, 0);
        sel0 = 2'd3;
        step();
        exp0("man_sel3", 8'h44, 3, 1, 0);

        // ---- stall, then a sub-cycle reset glitch between edges must be ignored
        en0 = 1'b0;
        step();
        exp0("stall0", 8'h44, 3, 0, 0);
        rst0 = 1'b0;
        #3;
        rst0 = 1'b1;
        step();
        exp0("glitch", 8'h44, 3, 0, 0);

        // ---- 3. scan with DWELL=2 from reset, data changing every cycle
        rst0 = 1'b0;
        step();
        exp0("rst_again", 8'h00, 0, 0, 0);
        rst0 = 1'b1; mode0 = 1'b1; en0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) data0[k*8 +: 8] = 8'(i*16 + k);
            step();
            exp0($sformatf("scan2_%0d", i), i*16 + seq3[i], seq3[i], 1, (i == 7) ? 1 : 0);
        end
        en0 = 1'b0;

        // ---- 4. out-of-range select on 5 channels, then DWELL=1 scan
        rst1 = 1'b1; en1 = 1'b1; mode1 = 1'b0;
        for (int k = 0; k < 5; k++) data1[k*8 +: 8] = 8'(8'hA0 + k);
        sel1 = 3'd2;
        step();
        exp1("c5_sel2", 8'hA2, 2, 1, 0);
        sel1 = 3'd6;
        step();
        exp1("c5_sel6", 8'hA2, 2, 0, 0);
        sel1 = 3'd4;
        step();
        exp1("c5_sel4", 8'hA4, 4, 1, 0);
        mode1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp1($sformatf("scan1_%0d", i), 8'hA0 + seq1[i], seq1[i], 1, (seq1[i] == 4) ? 1 : 0);
        end
        en1 = 1'b0;

        // ---- 5. enable stall in the middle of a DWELL=4 dwell
        rst2 = 1'b1; en2 = 1'b1; mode2 = 1'b1;
        for (int k = 0; k < 4; k++) data2[k*8 +: 8] = 8'(8'hC0 + k);
        for (int i = 0; i < 6; i++) begin
            step();
            exp2($sformatf("pre_%0d", i), 8'hC0 + i/4, i/4, 1, 0);
        end
        en2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp2($sformatf("stall_%0d", i), 8'hC1, 1, 0, 0);
        end
        en2 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            exp2($sformatf("post_%0d", i), 8'hC0 + seq5[i], seq5[i], 1, (i == 9) ? 1 : 0);
        end

        // ---- 6a. manual sel=3, then scan starts at ch3 with a full dwell
        mode2 = 1'b0; sel2 = 2'd3;
        step();
        exp2("m2s_man", 8'hC3, 3, 1, 0);
        mode2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp2($sformatf("m2s_%0d", i), (i < 4) ? 8'hC3 : 8'hC0, (i < 4) ? 3 : 0, 1, (i == 3) ? 1 : 0);
        end
        // continue to the first ch2 sample: 3 more ch0, 4 ch1, 1 ch2
        for (int i = 0; i < 8; i++) begin
            step();
        end
        exp2("at_ch2", 8'hC2, 2, 1, 0);

        // ---- 6b. reset for one edge mid-scan, then a fresh round from ch0
        rst2 = 1'b0;
        step();
        exp2("mid_rst", 8'h00, 0, 0, 0);
        rst2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp2($sformatf("restart_%0d", i), 8'hC0 + i/4, i/4, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
